muldiv_ctrl: RTL

//  Multi-cycle multiply/divide sequencer owning the HI/LO registers; sits in EX beside the ALU.

---
 rtl/muldiv_ctrl_pkg.sv | 36 +++
 rtl/muldiv_core.sv | 94 +++++++++
 rtl/muldiv_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes, HI/LO select codes,
// FSM states and default latencies.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MUL_NONE  = 3'd0,
    MUL_MULT  = 3'd1,
    MUL_MULTU = 3'd2,
    MUL_DIV   = 3'd3,
    MUL_DIVU  = 3'd4,
    MUL_MADD  = 3'd5,
    MUL_MSUB  = 3'd6,
    MUL_RSVD  = 3'd7
  } mul_op_e;

  localparam logic [1:0] HILO_HI = 2'b01;
  localparam logic [1:0] HILO_LO = 2'b10;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Codes 1..6 start an operation; 0 and the reserved code 7 are no-ops.
  function automatic logic is_mul_op(input logic [2:0] op);
    return (op != MUL_NONE) && (op != MUL_RSVD);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MUL_DIV) || (op == MUL_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational arithmetic for the sequencer: 64-bit products, madd/msub accumulation and
// truncating divide with the architectural divide-by-zero and overflow results.
module muldiv_core
  import muldiv_ctrl_pkg::*;
(
  input  logic [2:0]  i_mul_op,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo
);

  logic        w_mul_signed;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [63:0] w_acc;
  logic [63:0] w_madd;
  logic [63:0] w_msub;

  // Only multu is unsigned; madd/msub accumulate a signed product.
  assign w_mul_signed = (i_mul_op != MUL_MULTU);
  assign w_ext_a      = w_mul_signed ? {{32{i_op_a[31]}}, i_op_a} : {32'd0, i_op_a};
  assign w_ext_b      = w_mul_signed ? {{32{i_op_b[31]}}, i_op_b} : {32'd0, i_op_b};
  assign w_prod       = w_ext_a * w_ext_b;
  assign w_acc        = {i_hi, i_lo};
  assign w_madd       = w_acc + w_prod;
  assign w_msub       = w_acc - w_prod;

  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_divisor;
  logic [31:0] w_uquot;
  logic [31:0] w_urem;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Signed divide runs on magnitudes; quotient sign is the XOR, remainder follows the dividend.
  assign w_div_signed = (i_mul_op == MUL_DIV);
  assign w_neg_a      = w_div_signed & i_op_a[31];
  assign w_neg_b      = w_div_signed & i_op_b[31];
  assign w_abs_a      = w_neg_a ? (~i_op_a + 32'd1) : i_op_a;
  assign w_abs_b      = w_neg_b ? (~i_op_b + 32'd1) : i_op_b;
  assign w_div_zero   = (i_op_b == 32'd0);
  assign w_div_ovf    = w_div_signed && (i_op_a == 32'h8000_0000) && (i_op_b == 32'hFFFF_FFFF);
  assign w_divisor    = w_div_zero ? 32'd1 : w_abs_b;
  assign w_uquot      = w_abs_a / w_divisor;
  assign w_urem       = w_abs_a % w_divisor;
  assign w_quot       = (w_neg_a ^ w_neg_b) ? (~w_uquot + 32'd1) : w_uquot;
  assign w_rem        = w_neg_a ? (~w_urem + 32'd1) : w_urem;

  always_comb begin
    o_res_hi = 32'd0;
    o_res_lo = 32'd0;
    case (i_mul_op)
      MUL_MULT, MUL_MULTU: begin
        o_res_hi = w_prod[63:32];
        o_res_lo = w_prod[31:0];
      end
      MUL_MADD: begin
        o_res_hi = w_madd[63:32];
        o_res_lo = w_madd[31:0];
      end
      MUL_MSUB: begin
        o_res_hi = w_msub[63:32];
        o_res_lo = w_msub[31:0];
      end
      MUL_DIV, MUL_DIVU: begin
        if (w_div_zero) begin
          o_res_hi = i_op_a;
          o_res_lo = 32'hFFFF_FFFF;
        end else if (w_div_ovf) begin
          o_res_hi = 32'd0;
          o_res_lo = 32'h8000_0000;
        end else begin
          o_res_hi = w_rem;
          o_res_lo = w_quot;
        end
      end
      default: begin
        o_res_hi = 32'd0;
        o_res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs fixed-latency operations, handles
// MTHI/MTLO writes, MFHI/MFLO reads and the stall request for dependent ID-stage instructions.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mul_op,
  input  logic [1:0]  mthilo,
  input  logic [1:0]  mfhilo,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        cancel,
  input  logic        id_hilo_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_data
);

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;

  logic        w_accept;
  logic        w_commit;
  logic        w_mt_hi;
  logic        w_mt_lo;
  logic [31:0] w_core_hi;
  logic [31:0] w_core_lo;

  muldiv_core u_core (
    .i_mul_op (mul_op),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_res_hi (w_core_hi),
    .o_res_lo (w_core_lo)
  );

  // cnt counts remaining edges; the edge that sees cnt==0 is the commit edge.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (is_mul_op(mul_op) && !cancel) begin
          w_accept     = 1'b1;
          w_cnt_next   = is_div_op(mul_op) ? DIV_CNT_INIT : MUL_CNT_INIT;
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // A concurrent mul_op takes priority over MT; MT during BUSY is dropped.
  assign w_mt_hi = (r_state == ST_IDLE) && !cancel && !w_accept && (mthilo == HILO_HI);
  assign w_mt_lo = (r_state == ST_IDLE) && !cancel && !w_accept && (mthilo == HILO_LO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_pend_hi <= w_core_hi;
        r_pend_lo <= w_core_lo;
      end
      if (w_commit) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else begin
        if (w_mt_hi) r_hi <= op_a;
        if (w_mt_lo) r_lo <= op_a;
      end
    end
  end

  assign busy      = (r_state == ST_BUSY);
  assign stall_req = id_hilo_use & (busy | w_accept);

  always_comb begin
    rd_data = 32'd0;
    if (mfhilo == HILO_HI)      rd_data = r_hi;
    else if (mfhilo == HILO_LO) rd_data = r_lo;
  end

endmodule
